// File: rtl/cv32e40x_xif_coproc_stub_pkg.sv
// Shared types for the XIF reference coprocessor:
// opcode, ALU ops, bus bundles and the outstanding-entry layout.
package cv32e40x_xif_coproc_stub_pkg;

  localparam int X_ID_WIDTH  = 4;
  localparam int X_RFR_WIDTH = 32;
  localparam int X_RFW_WIDTH = 32;

  localparam logic [6:0] XIF_CUSTOM0_OPCODE = 7'b0001011;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_MIN = 3'b010,
    ALU_MAX = 3'b011
  } xif_alu_op_e;

  typedef struct packed {
    logic [31:0] instr;
    logic        accept;
  } x_compressed_resp_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic ecswrite;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic [31:0] wdata;
  } x_mem_req_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic [5:0]             ecsdata;
    logic [2:0]             ecswe;
    logic                   exc;
    logic [5:0]             exccode;
  } x_result_t;

  typedef struct packed {
    logic                   valid;
    logic                   committed;
    logic                   killed;
    logic [X_ID_WIDTH-1:0]  id;
    logic [4:0]             rd;
    logic [X_RFW_WIDTH-1:0] data;
  } xif_cp_entry_t;

  function automatic logic xif_decode_ok(
    input logic [6:0] opcode,
    input logic [2:0] funct3,
    input logic [6:0] funct7
  );
    return (opcode == XIF_CUSTOM0_OPCODE)
        && (funct7 == 7'd0) && !funct3[2];
  endfunction

endpackage

// File: rtl/cv32e40x_xif_coproc_stub_if.sv
// CORE-V XIF bundle as seen by one coprocessor.
// coproc_* modports are the coprocessor side, core is the driver.
interface cv32e40x_xif_coproc_stub_if #(
  parameter int X_NUM_RS = 2
);
  import cv32e40x_xif_coproc_stub_pkg::*;

  logic               compressed_valid;
  logic               compressed_ready;
  logic [15:0]        compressed_instr;
  x_compressed_resp_t compressed_resp;

  logic                                 issue_valid;
  logic                                 issue_ready;
  logic [31:0]                          issue_instr;
  logic [X_ID_WIDTH-1:0]                issue_id;
  logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] rs;
  logic [X_NUM_RS-1:0]                  rs_valid;
  x_issue_resp_t                        issue_resp;

  logic                  commit_valid;
  logic [X_ID_WIDTH-1:0] commit_id;
  logic                  commit_kill;

  logic       mem_valid;
  logic       mem_ready;
  x_mem_req_t mem_req;

  logic        mem_result_valid;
  logic [31:0] mem_result_rdata;

  logic      result_valid;
  logic      result_ready;
  x_result_t result;

  modport coproc_compressed (
    input  compressed_valid, compressed_instr,
    output compressed_ready, compressed_resp
  );
  modport coproc_issue (
    input  issue_valid, issue_instr, issue_id,
    input  rs, rs_valid,
    output issue_ready, issue_resp
  );
  modport coproc_commit (
    input commit_valid, commit_id, commit_kill
  );
  modport coproc_mem (
    input  mem_ready,
    output mem_valid, mem_req
  );
  modport coproc_mem_result (
    input mem_result_valid, mem_result_rdata
  );
  modport coproc_result (
    input  result_ready,
    output result_valid, result
  );
  modport core (
    output compressed_valid, compressed_instr,
    input  compressed_ready, compressed_resp,
    output issue_valid, issue_instr, issue_id,
    output rs, rs_valid,
    input  issue_ready, issue_resp,
    output commit_valid, commit_id, commit_kill,
    output mem_ready,
    input  mem_valid, mem_req,
    output mem_result_valid, mem_result_rdata,
    output result_ready,
    input  result_valid, result
  );

endinterface

// File: rtl/cv32e40x_xif_coproc_stub_alu.sv
// Single-cycle 32-bit ADD/SUB/signed MIN/MAX.
// Results wrap; no overflow indication.
module cv32e40x_xif_coproc_stub_alu
  import cv32e40x_xif_coproc_stub_pkg::*;
(
  input  xif_alu_op_e            op,
  input  logic [X_RFR_WIDTH-1:0] a,
  input  logic [X_RFR_WIDTH-1:0] b,
  output logic [X_RFW_WIDTH-1:0] res
);

  logic lt;

  assign lt = $signed(a) < $signed(b);

  // op may carry unsupported funct3 values; the entry is dropped then
  always_comb begin
    res = a + b;
    case (op)
      ALU_SUB: res = a - b;
      ALU_MIN: res = lt ? a : b;
      ALU_MAX: res = lt ? b : a;
      default: res = a + b;
    endcase
  end

endmodule

// File: rtl/cv32e40x_xif_coproc_stub.sv
// Reference XIF coprocessor: custom-0 ALU ops held in an
// in-order buffer until commit/kill, then retired as results.
module cv32e40x_xif_coproc_stub
  import cv32e40x_xif_coproc_stub_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  cv32e40x_xif_coproc_stub_if.coproc_compressed xif_compressed_if,
  cv32e40x_xif_coproc_stub_if.coproc_issue      xif_issue_if,
  cv32e40x_xif_coproc_stub_if.coproc_commit     xif_commit_if,
  cv32e40x_xif_coproc_stub_if.coproc_mem        xif_mem_if,
  cv32e40x_xif_coproc_stub_if.coproc_mem_result xif_mem_result_if,
  cv32e40x_xif_coproc_stub_if.coproc_result     xif_result_if
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  xif_cp_entry_t    ent_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic [31:0]            instr;
  logic                   accept;
  logic                   ready;
  logic                   push;
  logic                   pop;
  logic                   cm_new;
  logic [X_RFW_WIDTH-1:0] alu_res;
  xif_cp_entry_t          head;
  xif_cp_entry_t          new_ent;
  x_issue_resp_t          resp;
  x_result_t              res;
  logic                   unused;

  assign xif_compressed_if.compressed_ready = 1'b1;
  assign xif_compressed_if.compressed_resp  = '0;
  assign xif_mem_if.mem_valid = 1'b0;
  assign xif_mem_if.mem_req   = '0;

  assign instr  = xif_issue_if.issue_instr;
  assign accept = xif_decode_ok(
    instr[6:0], instr[14:12], instr[31:25]);

  always_comb begin
    resp           = '0;
    resp.accept    = accept;
    resp.writeback = accept;
  end

  assign xif_issue_if.issue_resp = resp;

  // Full check uses the current count only; a same-cycle pop
  // does not free a slot until the next cycle.
  assign ready = (count_q != CNT_W'(DEPTH))
              && (&xif_issue_if.rs_valid[1:0]);
  assign xif_issue_if.issue_ready = ready;

  assign push = xif_issue_if.issue_valid && ready && accept;

  cv32e40x_xif_coproc_stub_alu u_alu (
    .op  (xif_alu_op_e'(instr[14:12])),
    .a   (xif_issue_if.rs[0]),
    .b   (xif_issue_if.rs[1]),
    .res (alu_res)
  );

  assign cm_new = xif_commit_if.commit_valid
               && (xif_commit_if.commit_id == xif_issue_if.issue_id);

  always_comb begin
    new_ent           = '0;
    new_ent.valid     = 1'b1;
    new_ent.committed = cm_new && !xif_commit_if.commit_kill;
    new_ent.killed    = cm_new && xif_commit_if.commit_kill;
    new_ent.id        = xif_issue_if.issue_id;
    new_ent.rd        = instr[11:7];
    new_ent.data      = alu_res;
  end

  assign head = ent_q[rd_ptr_q];

  assign pop = head.valid && (head.killed
            || (head.committed && xif_result_if.result_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (xif_commit_if.commit_valid && ent_q[i].valid
            && ent_q[i].id == xif_commit_if.commit_id) begin
          if (xif_commit_if.commit_kill) ent_q[i].killed <= 1'b1;
          else ent_q[i].committed <= 1'b1;
        end
      end
      if (pop) ent_q[rd_ptr_q].valid <= 1'b0;
      if (push) ent_q[wr_ptr_q] <= new_ent;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Result is taken straight from the registered head entry,
  // so it stays put until the handshake pops it.
  always_comb begin
    res      = '0;
    res.id   = head.id;
    res.data = head.data;
    res.rd   = head.rd;
    res.we   = 1'b1;
  end

  assign xif_result_if.result_valid =
    head.valid && head.committed && !head.killed;
  assign xif_result_if.result = res;

  assign unused = ^{xif_compressed_if.compressed_valid,
                    xif_compressed_if.compressed_instr,
                    xif_mem_if.mem_ready,
                    xif_mem_result_if.mem_result_valid,
                    xif_mem_result_if.mem_result_rdata,
                    instr[24:15]};

endmodule

// File: tb/tb_cv32e40x_xif_coproc_stub.sv
// Bench for the XIF reference coprocessor: directed offload
// scenarios, then randomized traffic against a queue model.
module tb_cv32e40x_xif_coproc_stub;
  import cv32e40x_xif_coproc_stub_pkg::*;

  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  localparam logic [6:0] CUST = 7'b0001011;
  localparam logic [6:0] OPRR = 7'b0110011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   rand_ready = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;

  cv32e40x_xif_coproc_stub_if xif();

  cv32e40x_xif_coproc_stub #(.DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .xif_compressed_if (xif),
    .xif_issue_if      (xif),
    .xif_commit_if     (xif),
    .xif_mem_if        (xif),
    .xif_mem_result_if (xif),
    .xif_result_if     (xif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7,
    input logic [2:0] f3, input logic [4:0] rd,
    input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, rd, opc};
  endfunction

  function automatic logic ref_accept(input logic [31:0] i);
    return i[6:0] == 7'b0001011 && i[31:25] == 7'd0
        && i[14:12] <= 3'd3;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return (sa < sb) ? a : b;
      default: return (sa > sb) ? a : b;
    endcase
  endfunction

  function automatic x_result_t ref_res(input exp_t e);
    x_result_t r;
    r      = '0;
    r.id   = e.id;
    r.data = e.data;
    r.rd   = e.rd;
    r.we   = 1'b1;
    return r;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_ready) xif.result_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    xif.commit_valid = 1'b1;
    xif.commit_id    = id;
    xif.commit_kill  = kill;
    cyc(1);
    xif.commit_valid = 1'b0;
  endtask

  // mode 0: caller commits, 1: commit with issue, 2: next cycle
  task automatic issue_chk(input logic [6:0] f7,
    input logic [2:0] f3, input logic [6:0] opc,
    input logic [4:0] rd, input logic [3:0] id,
    input logic [31:0] a, input logic [31:0] b,
    input int mode, input logic kill);
    logic [31:0]   instr;
    logic          exp_acc;
    x_issue_resp_t resp;
    int            n;
    exp_t          e;
    instr   = mk(f7, f3, rd, opc);
    exp_acc = ref_accept(instr);
    n       = 0;
    xif.issue_valid = 1'b1;
    xif.issue_instr = instr;
    xif.issue_id    = id;
    xif.rs[0]       = a;
    xif.rs[1]       = b;
    #1;
    while (!xif.issue_ready && n < 60) begin
      cyc(1);
      #1;
      n++;
    end
    chk("issue_timeout", 64'(n >= 60), 64'(0));
    resp = xif.issue_resp;
    if (mode == 1) begin
      xif.commit_valid = 1'b1;
      xif.commit_id    = id;
      xif.commit_kill  = kill;
    end
    cyc(1);
    xif.issue_valid  = 1'b0;
    xif.commit_valid = 1'b0;
    chk("issue_resp", 64'(resp),
        64'(exp_acc ? 7'b1100000 : 7'b0000000));
    if (exp_acc && !kill) begin
      e.id   = id;
      e.rd   = rd;
      e.data = ref_alu(f3, a, b);
      exp_q.push_back(e);
    end
    if (mode == 2) commit(id, kill);
  endtask

  task automatic drain(input string tag);
    int n;
    bit saved;
    n     = 0;
    saved = rand_ready;
    rand_ready = 1'b0;
    xif.result_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      cyc(1);
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'(0));
    cyc(2);
    rand_ready = saved;
  endtask

  always @(negedge clk) begin
    if (!rst && xif.result_valid && xif.result_ready) begin
      if (exp_q.size() == 0) begin
        chk("result_extra", 64'(xif.result_valid), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", 64'(xif.result), 64'(ref_res(mon_e)));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  id;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    xif.compressed_valid = 1'b0;
    xif.compressed_instr = '0;
    xif.issue_valid      = 1'b0;
    xif.issue_instr      = '0;
    xif.issue_id         = '0;
    xif.rs               = '0;
    xif.rs_valid         = 2'b11;
    xif.commit_valid     = 1'b0;
    xif.commit_id        = '0;
    xif.commit_kill      = 1'b0;
    xif.mem_ready        = 1'b0;
    xif.mem_result_valid = 1'b0;
    xif.mem_result_rdata = '0;
    xif.result_ready     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_result_valid", 64'(xif.result_valid), 64'(0));
    chk("rst_issue_ready", 64'(xif.issue_ready), 64'(1));
    chk("cmp_ready", 64'(xif.compressed_ready), 64'(1));
    chk("cmp_resp", 64'(xif.compressed_resp), 64'(0));
    chk("mem_valid", 64'(xif.mem_valid), 64'(0));
    chk("mem_req", 64'(xif.mem_req), 64'(0));

    issue_chk(7'd0, 3'd0, CUST, 5'd9, 4'd3, 32'd5, 32'd7, 2, 1'b0);
    chk("add_valid", 64'(xif.result_valid), 64'(1));
    chk("add_result", 64'(xif.result),
        64'(ref_res('{4'd3, 5'd9, 32'd12})));
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("hold_valid", 64'(xif.result_valid), 64'(1));
      chk("hold_result", 64'(xif.result),
          64'(ref_res('{4'd3, 5'd9, 32'd12})));
    end
    xif.result_ready = 1'b1;
    cyc(1);
    chk("add_popped", 64'(xif.result_valid), 64'(0));

    issue_chk(7'd0, 3'd2, CUST, 5'd4, 4'd4,
              32'hFFFF_FFFE, 32'd3, 1, 1'b0);
    issue_chk(7'd0, 3'd1, CUST, 5'd5, 4'd5, 32'd0, 32'd1, 2, 1'b0);
    cyc(3);
    chk("min_sub_drained", 64'(exp_q.size()), 64'(0));

    issue_chk(7'd0, 3'd0, OPRR, 5'd6, 4'd6, 32'd1, 32'd2, 0, 1'b0);
    commit(4'd6, 1'b0);
    cyc(3);
    chk("rej_no_result", 64'(xif.result_valid), 64'(0));
    chk("rej_ready", 64'(xif.issue_ready), 64'(1));
    issue_chk(7'd0, 3'd4, CUST, 5'd7, 4'd7, 32'd1, 32'd2, 1, 1'b0);
    issue_chk(7'h20, 3'd0, CUST, 5'd7, 4'd8, 32'd1, 32'd2, 1, 1'b0);
    cyc(2);
    chk("rej_f3_f7", 64'(xif.result_valid), 64'(0));
    xif.rs_valid = 2'b01;
    #1;
    chk("rs_valid_gate", 64'(xif.issue_ready), 64'(0));
    xif.rs_valid = 2'b11;

    issue_chk(7'd0, 3'd0, CUST, 5'd1, 4'd0, 32'd10, 32'd1, 0, 1'b0);
    issue_chk(7'd0, 3'd1, CUST, 5'd2, 4'd1, 32'd10, 32'd2, 0, 1'b1);
    issue_chk(7'd0, 3'd3, CUST, 5'd3, 4'd2, 32'd10, 32'd3, 0, 1'b0);
    commit(4'd1, 1'b1);
    commit(4'd0, 1'b0);
    commit(4'd2, 1'b0);
    cyc(4);
    chk("kill_seq_drain", 64'(exp_q.size()), 64'(0));

    xif.result_ready = 1'b0;
    for (int i = 8; i < 12; i++)
      issue_chk(7'd0, 3'd0, CUST, 5'(i), 4'(i),
                32'(i), 32'd100, 0, 1'b0);
    chk("full_ready", 64'(xif.issue_ready), 64'(0));
    xif.result_ready = 1'b1;
    commit(4'd8, 1'b0);
    chk("full_before_pop", 64'(xif.issue_ready), 64'(0));
    cyc(1);
    chk("full_after_pop", 64'(xif.issue_ready), 64'(1));
    xif.result_ready = 1'b0;
    commit(4'd9, 1'b0);
    commit(4'd10, 1'b0);
    chk("pend_valid", 64'(xif.result_valid), 64'(1));
    rst = 1'b1;
    cyc(1);
    chk("midrst_valid", 64'(xif.result_valid), 64'(0));
    chk("midrst_ready", 64'(xif.issue_ready), 64'(1));
    rst = 1'b0;
    exp_q.delete();
    commit(4'd11, 1'b0);
    cyc(3);
    chk("post_rst_empty", 64'(xif.result_valid), 64'(0));

    rand_ready = 1'b1;
    id = 4'd0;
    for (int it = 0; it < 64; it++) begin
      f3  = 3'($urandom_range(0, 4));
      opc = ($urandom_range(0, 7) == 0) ? OPRR : CUST;
      f7  = ($urandom_range(0, 9) == 0) ? 7'h20 : 7'h00;
      a   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
      issue_chk(f7, f3, opc, 5'($urandom_range(0, 31)), id, a, b,
                $urandom_range(1, 2), ($urandom_range(0, 3) == 0));
      id = id + 4'd1;
      if (it % 8 == 7) drain("rand_drain");
    end
    rand_ready = 1'b0;
    drain("final_drain");
    chk("final_idle", 64'(xif.result_valid), 64'(0));
    chk("final_ready", 64'(xif.issue_ready), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
